// File: rtl/r_type_pkg.sv
// Shared types and encodings for the R-type control unit and its decoder.
package r_type_pkg;

  // Control FSM states, one per phase of the multi-cycle instruction flow
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // ALU operation codes seen by the datapath
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  // Supported funct field values (op == 0 only)
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLLV = 6'h04;

  localparam logic [5:0]  OP_RTYPE  = 6'h00;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

  // Map a funct field to {legal, alu_op}; unknown functs come back as {0, AND}
  function automatic logic [3:0] funct_to_aluop(input logic [5:0] funct);
    logic [3:0] res;
    case (funct)
      FN_AND:  res = {1'b1, ALU_AND};
      FN_OR:   res = {1'b1, ALU_OR};
      FN_XOR:  res = {1'b1, ALU_XOR};
      FN_NOR:  res = {1'b1, ALU_NOR};
      FN_ADD:  res = {1'b1, ALU_ADD};
      FN_SUB:  res = {1'b1, ALU_SUB};
      FN_SLT:  res = {1'b1, ALU_SLT};
      FN_SLLV: res = {1'b1, ALU_SLLV};
      default: res = {1'b0, ALU_AND};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/r_type_decode.sv
// Combinational instruction decode: ALU operation, legality and HALT detection.
module r_type_decode
  import r_type_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  alu_op,
  output logic        legal,
  output logic        halt
);

  logic [3:0] lookup;

  // Illegal encodings report ALU_AND so a discarded op never carries stray bits
  always_comb begin
    lookup = funct_to_aluop(inst[5:0]);
    halt   = (inst == HALT_INST);
    legal  = (inst[31:26] == OP_RTYPE) && lookup[3];
    alu_op = legal ? lookup[2:0] : ALU_AND;
  end

endmodule

// File: rtl/r_type_ctrl.sv
// Multi-cycle R-type control unit: FETCH/DECODE/EXEC/WB sequencing, pc,
// instruction register, retired-instruction counter and sticky status flags.
module r_type_ctrl
  import r_type_pkg::*;
#(
  parameter int              PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [31:0]     inst,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      rs_addr,
  output logic [4:0]      rt_addr,
  output logic [4:0]      rd_addr,
  output logic [2:0]      alu_op,
  output logic            rf_we,
  output logic            flag_we,
  output logic            illegal,
  output logic            halted,
  output logic [15:0]     instret
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  // Only the register-address fields of IR are needed after DECODE; the
  // op/funct information lives on in the latched decode bits.
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [14:0]     ir_q, ir_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            legal_q, legal_d;
  logic            illegal_q, illegal_d;
  logic [15:0]     instret_q, instret_d;

  logic [2:0]      dec_alu_op;
  logic            dec_legal;
  logic            dec_halt;

  r_type_decode u_decode (
    .inst   (inst),
    .alu_op (dec_alu_op),
    .legal  (dec_legal),
    .halt   (dec_halt)
  );

  // State register and datapath-control flops; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_op_q  <= ALU_AND;
      legal_q   <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      legal_q   <= legal_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic; pc and instret only move on the edge leaving WB
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    legal_d   = legal_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d     = inst[25:11];
        alu_op_d = dec_alu_op;
        legal_d  = dec_legal;
        state_d  = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        if (!legal_q) illegal_d = 1'b1;
        pc_d      = pc_q + PC_ONE;
        instret_d = instret_q + 16'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: derived only from flops so the write enables cannot glitch
  always_comb begin
    pc      = pc_q;
    rs_addr = ir_q[14:10];
    rt_addr = ir_q[9:5];
    rd_addr = ir_q[4:0];
    alu_op  = alu_op_q;
    flag_we = (state_q == S_WB) && legal_q;
    rf_we   = (state_q == S_WB) && legal_q && (ir_q[4:0] != 5'd0);
    illegal = illegal_q;
    halted  = (state_q == S_HALT);
    instret = instret_q;
  end

endmodule

// File: tb/tb_r_type_ctrl.sv
// Self-checking bench for r_type_ctrl: table-driven program plus run-drop,
// mid-instruction reset and small-pc wrap sequences.
module tb_r_type_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, run2;
  logic [31:0] inst, inst2;

  logic [5:0]  pc;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [2:0]  alu_op;
  logic        rf_we, flag_we, illegal, halted;
  logic [15:0] instret;

  logic [1:0]  pc2;
  logic [4:0]  rs2, rt2, rd2;
  logic [2:0]  alu_op2;
  logic        rf_we2, flag_we2, illegal2, halted2;
  logic [15:0] instret2;

  logic [31:0] rom  [64];
  logic [31:0] rom2 [4];

  int checks = 0;
  int errors = 0;

  r_type_ctrl #(.PC_W(6)) dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .pc(pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .alu_op(alu_op),
    .rf_we(rf_we), .flag_we(flag_we), .illegal(illegal), .halted(halted),
    .instret(instret)
  );

  r_type_ctrl #(.PC_W(2)) dut2 (
    .clk(clk), .rst(rst), .run(run2), .inst(inst2), .pc(pc2),
    .rs_addr(rs2), .rt_addr(rt2), .rd_addr(rd2), .alu_op(alu_op2),
    .rf_we(rf_we2), .flag_we(flag_we2), .illegal(illegal2), .halted(halted2),
    .instret(instret2)
  );

  // One-cycle synchronous instruction ROMs
  always @(posedge clk) inst  <= rom[pc];
  always @(posedge clk) inst2 <= rom2[pc2];

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  alu_op;
    logic [4:0]  rs, rt, rd;
    logic        rf_we, flag_we, illegal_after;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; run2 = 1'b0;

    vecs[0]  = '{32'h00221820, 3'b100, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 1'b0}; // add r3,r1,r2
    vecs[1]  = '{32'h00A62024, 3'b000, 5'd5, 5'd6, 5'd4,  1'b1, 1'b1, 1'b0}; // and r4,r5,r6
    vecs[2]  = '{32'h00223825, 3'b001, 5'd1, 5'd2, 5'd7,  1'b1, 1'b1, 1'b0}; // or
    vecs[3]  = '{32'h00224026, 3'b010, 5'd1, 5'd2, 5'd8,  1'b1, 1'b1, 1'b0}; // xor
    vecs[4]  = '{32'h00224827, 3'b011, 5'd1, 5'd2, 5'd9,  1'b1, 1'b1, 1'b0}; // nor
    vecs[5]  = '{32'h00225022, 3'b101, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0}; // sub
    vecs[6]  = '{32'h0022582A, 3'b110, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b0}; // slt
    vecs[7]  = '{32'h00226004, 3'b111, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0}; // sllv
    vecs[8]  = '{32'h8C000000, 3'b000, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b1}; // op!=0
    vecs[9]  = '{32'h00221820, 3'b100, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 1'b1}; // add after illegal
    vecs[10] = '{32'h00220020, 3'b100, 5'd1, 5'd2, 5'd0,  1'b0, 1'b1, 1'b1}; // add rd=0
    vecs[11] = '{32'h00221821, 3'b000, 5'd1, 5'd2, 5'd3,  1'b0, 1'b0, 1'b1}; // unlisted funct

    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int i = 0; i < 12; i++) rom[i] = vecs[i].inst;
    rom[12] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) rom2[i] = 32'h00221820;

    // Reset, then idle with run low
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset pc", pc, 0);
    check("reset rf_we", rf_we, 0);
    check("reset flag_we", flag_we, 0);
    check("reset illegal", illegal, 0);
    check("reset halted", halted, 0);
    check("reset instret", instret, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset alu_op", alu_op, 0);

    // Table-driven program, run held high: WB every 4 cycles
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat (i == 0 ? 4 : 3) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d wb alu_op", i), alu_op, vecs[i].alu_op);
      check($sformatf("v%0d wb rs", i), rs_addr, vecs[i].rs);
      check($sformatf("v%0d wb rt", i), rt_addr, vecs[i].rt);
      check($sformatf("v%0d wb rd", i), rd_addr, vecs[i].rd);
      check($sformatf("v%0d wb rf_we", i), rf_we, vecs[i].rf_we);
      check($sformatf("v%0d wb flag_we", i), flag_we, vecs[i].flag_we);
      check($sformatf("v%0d wb pc", i), pc, i);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d post pc", i), pc, i + 1);
      check($sformatf("v%0d post instret", i), instret, i + 1);
      check($sformatf("v%0d post illegal", i), illegal, vecs[i].illegal_after);
      check($sformatf("v%0d post rf_we", i), rf_we, 0);
      check($sformatf("v%0d post flag_we", i), flag_we, 0);
    end

    // HALT at pc=12: frozen despite run=1
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("halt halted", halted, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("halt pc frozen", pc, 12);
    check("halt instret", instret, 12);
    check("halt still halted", halted, 1);
    check("halt rf_we", rf_we, 0);
    check("halt flag_we", flag_we, 0);

    // Drop run during EXEC: WB still happens, then IDLE
    rst = 1'b0; run = 1'b0;
    rom[0] = 32'h00221820;
    rom[1] = 32'h00A62024;
    @(negedge clk);
    check("rst2 halted cleared", halted, 0);
    check("rst2 illegal cleared", illegal, 0);
    rst = 1'b1; run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("exec rd_addr", rd_addr, 3);
    check("exec rf_we", rf_we, 0);
    run = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rundrop wb rf_we", rf_we, 1);
    check("rundrop wb flag_we", flag_we, 1);
    @(posedge clk); @(negedge clk);
    check("rundrop pc", pc, 1);
    check("rundrop instret", instret, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle pc", pc, 1);
    check("idle flag_we", flag_we, 0);

    // Reset asserted mid-EXEC: instruction discarded, no write
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("exec2 rd_addr", rd_addr, 4);
    #1 rst = 1'b0;
    #1;
    check("async pc", pc, 0);
    check("async rd_addr", rd_addr, 0);
    check("async alu_op", alu_op, 0);
    check("async instret", instret, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("inrst%0d rf_we", k), rf_we, 0);
      check($sformatf("inrst%0d flag_we", k), flag_we, 0);
    end
    run = 1'b0; rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("postrst pc", pc, 0);
    check("postrst instret", instret, 0);

    // PC_W=2 instance: pc wraps 3 -> 0 over 5 instructions
    run2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (i == 0 ? 4 : 3) @(posedge clk);
      @(negedge clk);
      check($sformatf("w%0d wb rf_we", i), rf_we2, 1);
      check($sformatf("w%0d wb pc", i), pc2, i % 4);
      @(posedge clk); @(negedge clk);
      check($sformatf("w%0d post pc", i), pc2, (i + 1) % 4);
      check($sformatf("w%0d post instret", i), instret2, i + 1);
    end
    run2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r_type_ctrl.md
# r_type_ctrl

Multi-cycle control unit that sequences the R-type datapath (register file, ALU, zf/of flag registers) from a synchronous instruction ROM. It owns the program counter, instruction register and a retired-instruction counter. Each instruction is fetched, decoded into register addresses and an ALU operation, executed, and written back. It sits between the instruction ROM and the datapath inside the top-level CPU.

## Interface

Parameters:
- PC_W, 6, instruction ROM word-address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; low clears all state immediately
- run  in  1  1 = execute instructions; sampled in IDLE and in WB
- inst  in  32  ROM read data, valid the cycle after pc changes (1-cycle synchronous ROM)
- pc  out  PC_W  ROM word address
- rs_addr, rt_addr, rd_addr  out  5 each  register file addresses from IR[25:21], IR[20:16], IR[15:11]
- alu_op  out  3  ALU operation code
- rf_we  out  1  register file write enable
- flag_we  out  1  zf/of register load enable
- illegal  out  1  sticky: an unsupported instruction was seen
- halted  out  1  HALT instruction reached
- instret  out  16  retired-instruction count

## Operation

- Instruction format: op[31:26], rs, rt, rd, shamt[10:6], funct[5:0]. Supported only when op==0.
- funct → alu_op: 0x24 AND=000, 0x25 OR=001, 0x26 XOR=010, 0x27 NOR=011, 0x20 ADD=100, 0x22 SUB=101, 0x2A SLT=110, 0x04 SLLV=111.
- inst==32'hFFFF_FFFF is HALT; everything else with op!=0 or unlisted funct is illegal.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: run=1 → FETCH, else stay.
  - FETCH: pc stable, ROM reading → DECODE.
  - DECODE: IR ← inst; alu_op and illegal/halt decode latched → HALT if halt, else EXEC.
  - EXEC: register addresses and alu_op stable, ALU settles → WB.
  - WB: rf_we=1 and flag_we=1 for legal instructions; rf_we forced 0 if rd_addr==0. Illegal: both 0, illegal ← 1. Then pc ← pc+1 (mod 2^PC_W) and instret ← instret+1 (wraps at 16 bits, illegal counts too). Next state is FETCH if run=1, else IDLE.
  - HALT: halted=1, pc frozen, no enables; exit only by reset.
- Deasserting run mid-instruction does not abort it; the current instruction completes through WB, then goes to IDLE.

## Timing

- Reset values: state IDLE, pc=RESET_PC, IR=0 (so addresses=0, alu_op=000), rf_we=0, flag_we=0, illegal=0, halted=0, instret=0.
- Legal instruction: exactly 4 cycles (FETCH, DECODE, EXEC, WB). With run held high, a new FETCH follows WB with no gap.
- IDLE→FETCH: 1 cycle after run is sampled high.
- rf_we and flag_we are Moore outputs decoded from the state register plus latched decode bits only. They are glitch-free and high for exactly one cycle per legal instruction.
- pc changes only on the clock edge that leaves WB. The ROM output used in DECODE therefore always corresponds to the current pc.
- rst low in any state: outputs return to reset values asynchronously. A partially executed instruction is discarded, with no write.

## Structure

- Package r_type_pkg:
  - state enum
  - alu_op constants
  - funct constants
  - HALT_INST constant
  - function funct_to_aluop returning {legal, alu_op}
- Sub-module r_type_decode: combinational decode of inst into alu_op, legal and halt. Instantiated once, with outputs latched in DECODE.
- Top level holds the FSM, pc, IR, instret and the sticky flags.

## Test plan

- Reset with run=0, hold 10 cycles: pc=0, all enables 0, state IDLE, instret=0.
- ROM[0]=0x00221820 (add r3,r1,r2), run=1: in WB cycle 4 rf_we=1, flag_we=1, rd=3, rs=1, rt=2, alu_op=100; pc=1 and instret=1 after.
- Program of AND/OR/XOR/NOR/SUB/SLT/SLLV: alu_op sequence 000,001,010,011,101,110,111; one WB every 4 cycles; instret=7.
- ROM word 0x8C000000 (op≠0) then add: no rf_we for the first instruction, illegal=1 sticky, second executes normally, pc advances by 2.
- add with rd=0: flag_we=1, rf_we=0. HALT at pc=5: halted=1, pc stays 5 for 20 cycles despite run=1.
- Drop run during EXEC: WB still occurs, then IDLE. Assert rst low mid-EXEC of another instruction: no rf_we pulse, pc=RESET_PC. PC_W=2 over 5 instructions: pc wraps 3→0.
